// File: rtl/rob_multi.sv
// Reorder buffer with in-order retirement, two writeback channels (ALU with branch
// resolution, load/store), dual operand lookup with same-cycle forwarding and flush.
module rob_multi #(
  parameter int PTR_W  = 3,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  input  logic [RD_W-1:0]   disp_rd,
  input  logic [DATA_W-1:0] disp_pc,
  output logic              disp_ready,
  output logic [PTR_W-1:0]  disp_tag,
  input  logic              wb0_valid,
  input  logic [PTR_W-1:0]  wb0_tag,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb0_mispredict,
  input  logic [DATA_W-1:0] wb0_target,
  input  logic              wb1_valid,
  input  logic [PTR_W-1:0]  wb1_tag,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic [PTR_W-1:0]  q1_tag,
  input  logic [PTR_W-1:0]  q2_tag,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data,
  output logic              commit_valid,
  output logic [RD_W-1:0]   commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [DATA_W-1:0] commit_pc,
  output logic              flush,
  output logic [DATA_W-1:0] flush_pc
);

  localparam int DEPTH = 1 << PTR_W;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0]  busy, rdy, mis;
  logic [RD_W-1:0]   rd_q   [DEPTH];
  logic [DATA_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] tgt_q  [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W:0]    count;

  logic dispatch, wb0_hit, wb1_hit;

  assign commit_valid = (count != '0) && rdy[head];
  assign flush        = commit_valid && mis[head];
  assign flush_pc     = flush ? tgt_q[head] : '0;
  assign commit_rd    = commit_valid ? rd_q[head]   : '0;
  assign commit_data  = commit_valid ? data_q[head] : '0;
  assign commit_pc    = commit_valid ? pc_q[head]   : '0;

  // A retiring slot is not reusable until the next cycle; flush blocks dispatch outright.
  assign disp_ready = (count != FULL) && !flush;
  assign disp_tag   = tail;
  assign dispatch   = disp_valid && disp_ready;

  // wb0 wins a same-tag collision, so wb1 is suppressed whenever wb0 targets that tag.
  assign wb0_hit = wb0_valid && busy[wb0_tag];
  assign wb1_hit = wb1_valid && busy[wb1_tag] && !(wb0_valid && (wb0_tag == wb1_tag));

  always_comb begin
    q1_ready = 1'b0;
    q1_data  = '0;
    if (busy[q1_tag]) begin
      if (wb0_valid && (wb0_tag == q1_tag)) begin
        q1_ready = 1'b1;
        q1_data  = wb0_data;
      end else if (wb1_valid && (wb1_tag == q1_tag)) begin
        q1_ready = 1'b1;
        q1_data  = wb1_data;
      end else if (rdy[q1_tag]) begin
        q1_ready = 1'b1;
        q1_data  = data_q[q1_tag];
      end
    end
  end

  always_comb begin
    q2_ready = 1'b0;
    q2_data  = '0;
    if (busy[q2_tag]) begin
      if (wb0_valid && (wb0_tag == q2_tag)) begin
        q2_ready = 1'b1;
        q2_data  = wb0_data;
      end else if (wb1_valid && (wb1_tag == q2_tag)) begin
        q2_ready = 1'b1;
        q2_data  = wb1_data;
      end else if (rdy[q2_tag]) begin
        q2_ready = 1'b1;
        q2_data  = data_q[q2_tag];
      end
    end
  end

  // Control state; a flush retires the head implicitly by emptying the whole buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= '0;
      rdy   <= '0;
      mis   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      busy  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (dispatch) begin
        busy[tail] <= 1'b1;
        rdy[tail]  <= 1'b0;
        mis[tail]  <= 1'b0;
        tail       <= tail + PTR_W'(1);
      end
      if (wb0_hit) begin
        rdy[wb0_tag] <= 1'b1;
        mis[wb0_tag] <= wb0_mispredict;
      end
      if (wb1_hit) begin
        rdy[wb1_tag] <= 1'b1;
      end
      if (commit_valid) begin
        busy[head] <= 1'b0;
        head       <= head + PTR_W'(1);
      end
      case ({dispatch, commit_valid})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (dispatch) begin
        rd_q[tail] <= disp_rd;
        pc_q[tail] <= disp_pc;
      end
      if (wb0_hit) begin
        data_q[wb0_tag] <= wb0_data;
        tgt_q[wb0_tag]  <= wb0_target;
      end
      if (wb1_hit) begin
        data_q[wb1_tag] <= wb1_data;
      end
    end
  end

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: fill, out-of-order writeback, wrap-around,
// misprediction flush, writeback collision/forwarding and mid-run reset.
module tb_rob_multi;

  logic        clk;
  logic        rst;
  logic        disp_valid;
  logic [4:0]  disp_rd;
  logic [31:0] disp_pc;
  logic        disp_ready;
  logic [2:0]  disp_tag;
  logic        wb0_valid;
  logic [2:0]  wb0_tag;
  logic [31:0] wb0_data;
  logic        wb0_mispredict;
  logic [31:0] wb0_target;
  logic        wb1_valid;
  logic [2:0]  wb1_tag;
  logic [31:0] wb1_data;
  logic [2:0]  q1_tag, q2_tag;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_data, q2_data;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data, commit_pc;
  logic        flush;
  logic [31:0] flush_pc;

  int checks = 0;
  int errors = 0;

  rob_multi #(.PTR_W(3), .DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_pc(disp_pc),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_data(wb0_data),
    .wb0_mispredict(wb0_mispredict), .wb0_target(wb0_target),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_data(wb1_data),
    .q1_tag(q1_tag), .q2_tag(q2_tag),
    .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_pc(commit_pc),
    .flush(flush), .flush_pc(flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearInputs();
    disp_valid     = 1'b0;
    disp_rd        = '0;
    disp_pc        = '0;
    wb0_valid      = 1'b0;
    wb0_tag        = '0;
    wb0_data       = '0;
    wb0_mispredict = 1'b0;
    wb0_target     = '0;
    wb1_valid      = 1'b0;
    wb1_tag        = '0;
    wb1_data       = '0;
    q1_tag         = '0;
    q2_tag         = '0;
  endtask

  // Clocks in whatever inputs are set, then returns 1 ns past the edge with inputs idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic dispatchOne(input logic [4:0] rd, input logic [31:0] pc);
    disp_valid = 1'b1;
    disp_rd    = rd;
    disp_pc    = pc;
    applyStimulus();
  endtask

  initial begin
    clearInputs();
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    #1;

    checkOutput("rst_disp_ready", 64'(disp_ready), 64'd1);
    checkOutput("rst_disp_tag", 64'(disp_tag), 64'd0);
    checkOutput("rst_commit_valid", 64'(commit_valid), 64'd0);
    checkOutput("rst_flush", 64'(flush), 64'd0);
    checkOutput("rst_q1_ready", 64'(q1_ready), 64'd0);
    checkOutput("rst_q2_ready", 64'(q2_ready), 64'd0);
    checkOutput("rst_commit_data", 64'(commit_data), 64'd0);
    checkOutput("rst_commit_pc", 64'(commit_pc), 64'd0);
    checkOutput("rst_commit_rd", 64'(commit_rd), 64'd0);
    checkOutput("rst_flush_pc", 64'(flush_pc), 64'd0);
    checkOutput("rst_q1_data", 64'(q1_data), 64'd0);

    // Fill all eight slots with no writebacks.
    for (int i = 0; i < 8; i++) begin
      disp_valid = 1'b1;
      disp_rd    = 5'(i + 1);
      disp_pc    = 32'h1000 + 32'(4 * i);
      #1;
      checkOutput("fill_tag", 64'(disp_tag), 64'(i));
      checkOutput("fill_ready", 64'(disp_ready), 64'd1);
      applyStimulus();
    end
    #1;
    checkOutput("full_ready", 64'(disp_ready), 64'd0);
    checkOutput("full_commit_valid", 64'(commit_valid), 64'd0);

    // Ninth request plus a writeback to the head.
    disp_valid = 1'b1;
    disp_pc    = 32'hBAD0;
    wb0_valid  = 1'b1;
    wb0_tag    = 3'd0;
    wb0_data   = 32'hD0;
    #1;
    checkOutput("ninth_ready", 64'(disp_ready), 64'd0);
    applyStimulus();
    #1;
    checkOutput("ninth_tag", 64'(disp_tag), 64'd0);

    // Commit while full: the retiring slot must not be offered to dispatch yet.
    disp_valid = 1'b1;
    disp_pc    = 32'hBAD4;
    #1;
    checkOutput("full_commit", 64'(commit_valid), 64'd1);
    checkOutput("full_commit_pc", 64'(commit_pc), 64'h1000);
    checkOutput("full_commit_data", 64'(commit_data), 64'hD0);
    checkOutput("full_commit_rd", 64'(commit_rd), 64'd1);
    checkOutput("full_commit_ready", 64'(disp_ready), 64'd0);
    applyStimulus();
    #1;
    checkOutput("after_commit_ready", 64'(disp_ready), 64'd1);
    checkOutput("after_commit_tag", 64'(disp_tag), 64'd0);
    checkOutput("after_commit_cv", 64'(commit_valid), 64'd0);

    // Reset with the buffer nearly full.
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    #1;
    checkOutput("rst2_ready", 64'(disp_ready), 64'd1);
    checkOutput("rst2_tag", 64'(disp_tag), 64'd0);

    // Out-of-order writeback, in-order commit.
    dispatchOne(5'd1, 32'h200);
    dispatchOne(5'd2, 32'h204);
    dispatchOne(5'd3, 32'h208);
    wb0_valid = 1'b1; wb0_tag = 3'd2; wb0_data = 32'h22;
    q1_tag    = 3'd2;
    #1;
    checkOutput("ooo_fwd_ready", 64'(q1_ready), 64'd1);
    checkOutput("ooo_fwd_data", 64'(q1_data), 64'h22);
    checkOutput("ooo_cv0", 64'(commit_valid), 64'd0);
    applyStimulus();
    wb1_valid = 1'b1; wb1_tag = 3'd0; wb1_data = 32'h20;
    q1_tag    = 3'd2;
    q2_tag    = 3'd1;
    #1;
    checkOutput("ooo_stored_ready", 64'(q1_ready), 64'd1);
    checkOutput("ooo_stored_data", 64'(q1_data), 64'h22);
    checkOutput("ooo_pending_q2", 64'(q2_ready), 64'd0);
    checkOutput("ooo_cv1", 64'(commit_valid), 64'd0);
    applyStimulus();
    wb0_valid = 1'b1; wb0_tag = 3'd1; wb0_data = 32'h21;
    #1;
    checkOutput("ooo_c0_valid", 64'(commit_valid), 64'd1);
    checkOutput("ooo_c0_pc", 64'(commit_pc), 64'h200);
    checkOutput("ooo_c0_data", 64'(commit_data), 64'h20);
    applyStimulus();
    #1;
    checkOutput("ooo_c1_valid", 64'(commit_valid), 64'd1);
    checkOutput("ooo_c1_pc", 64'(commit_pc), 64'h204);
    checkOutput("ooo_c1_data", 64'(commit_data), 64'h21);
    applyStimulus();
    #1;
    checkOutput("ooo_c2_valid", 64'(commit_valid), 64'd1);
    checkOutput("ooo_c2_pc", 64'(commit_pc), 64'h208);
    checkOutput("ooo_c2_rd", 64'(commit_rd), 64'd3);
    applyStimulus();
    #1;
    checkOutput("ooo_empty", 64'(commit_valid), 64'd0);
    checkOutput("ooo_tail", 64'(disp_tag), 64'd3);

    // Ten dispatch/writeback/commit rounds starting at tag 3, wrapping 7 -> 0.
    for (int i = 0; i < 10; i++) begin
      disp_valid = 1'b1;
      disp_rd    = 5'(i);
      disp_pc    = 32'h300 + 32'(4 * i);
      #1;
      checkOutput("wrap_tag", 64'(disp_tag), 64'((3 + i) % 8));
      applyStimulus();
      wb0_valid = 1'b1;
      wb0_tag   = 3'((3 + i) % 8);
      wb0_data  = 32'h50 + 32'(i);
      applyStimulus();
      #1;
      checkOutput("wrap_commit_pc", 64'(commit_pc), 64'h300 + 64'(4 * i));
      checkOutput("wrap_commit_data", 64'(commit_data), 64'h50 + 64'(i));
      applyStimulus();
    end
    #1;
    checkOutput("wrap_final_tag", 64'(disp_tag), 64'd5);

    // Misprediction on tag 1 after tag 0 retires.
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    dispatchOne(5'd4, 32'h400);
    dispatchOne(5'd5, 32'h404);
    dispatchOne(5'd6, 32'h408);
    wb0_valid = 1'b1; wb0_tag = 3'd1; wb0_data = 32'h11;
    wb0_mispredict = 1'b1; wb0_target = 32'h100;
    wb1_valid = 1'b1; wb1_tag = 3'd0; wb1_data = 32'h10;
    applyStimulus();
    #1;
    checkOutput("mp_c0_pc", 64'(commit_pc), 64'h400);
    checkOutput("mp_c0_flush", 64'(flush), 64'd0);
    checkOutput("mp_c0_flush_pc", 64'(flush_pc), 64'd0);
    applyStimulus();
    disp_valid = 1'b1; disp_pc = 32'h500;
    wb1_valid  = 1'b1; wb1_tag = 3'd2; wb1_data = 32'h12;
    #1;
    checkOutput("mp_flush", 64'(flush), 64'd1);
    checkOutput("mp_flush_pc", 64'(flush_pc), 64'h100);
    checkOutput("mp_commit_pc", 64'(commit_pc), 64'h404);
    checkOutput("mp_disp_ready", 64'(disp_ready), 64'd0);
    applyStimulus();
    q1_tag = 3'd2;
    #1;
    checkOutput("mp_after_flush", 64'(flush), 64'd0);
    checkOutput("mp_after_tag", 64'(disp_tag), 64'd0);
    checkOutput("mp_after_ready", 64'(disp_ready), 64'd1);
    checkOutput("mp_after_cv", 64'(commit_valid), 64'd0);
    checkOutput("mp_after_q1", 64'(q1_ready), 64'd0);

    // Same-tag collision on tag 3.
    for (int i = 0; i < 4; i++) dispatchOne(5'(i), 32'h600 + 32'(4 * i));
    wb0_valid = 1'b1; wb0_tag = 3'd3; wb0_data = 32'hA;
    wb1_valid = 1'b1; wb1_tag = 3'd3; wb1_data = 32'hB;
    q1_tag    = 3'd3;
    #1;
    checkOutput("col_q1_ready", 64'(q1_ready), 64'd1);
    checkOutput("col_q1_data", 64'(q1_data), 64'hA);
    applyStimulus();
    q1_tag = 3'd0;
    q2_tag = 3'd3;
    #1;
    checkOutput("col_q2_ready", 64'(q2_ready), 64'd1);
    checkOutput("col_stored", 64'(q2_data), 64'hA);
    checkOutput("col_q1_pending", 64'(q1_ready), 64'd0);
    checkOutput("col_cv", 64'(commit_valid), 64'd0);

    // Reset with five entries in flight, overriding concurrent dispatch/writeback.
    dispatchOne(5'd9, 32'h700);
    rst        = 1'b1;
    disp_valid = 1'b1; disp_pc = 32'h800;
    wb0_valid  = 1'b1; wb0_tag = 3'd0; wb0_data = 32'hEE;
    applyStimulus();
    rst    = 1'b0;
    q2_tag = 3'd3;
    #1;
    checkOutput("midrst_ready", 64'(disp_ready), 64'd1);
    checkOutput("midrst_cv", 64'(commit_valid), 64'd0);
    checkOutput("midrst_tag", 64'(disp_tag), 64'd0);
    checkOutput("midrst_q2", 64'(q2_ready), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
